// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: stores to BASE_ADDR queue bytes in a small FIFO,
// loads from BASE_ADDR+4 return {overflow, full, busy}.
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0100,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] DataAdr,
  input  logic [31:0] WriteData,
  output logic [31:0] rdata,
  output logic        sel,
  output logic        tx,
  output logic        busy
);

  localparam int unsigned BaudW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW  = PtrW + 1;
  localparam logic [BaudW-1:0] BaudMax = BaudW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0]  CntFull = CntW'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e            state_q;
  logic [BaudW-1:0]  baud_q;
  logic [2:0]        bit_idx_q;
  logic [7:0]        shift_q;
  logic              tx_q;

  logic [7:0]        mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]   rd_ptr_q;
  logic [PtrW-1:0]   wr_ptr_q;
  logic [CntW-1:0]   count_q;
  logic              overflow_q;

  logic addr_tx, addr_st, push_req, clr_req;
  logic full, empty, bit_end, pop, push, ovf_set;
  logic [7:0] head;

  always_comb begin
    addr_tx  = (DataAdr == BASE_ADDR);
    addr_st  = (DataAdr == (BASE_ADDR + 32'd4));
    push_req = MemWrite && addr_tx;
    clr_req  = MemWrite && addr_st && WriteData[2];
    full     = (count_q == CntFull);
    empty    = (count_q == '0);
    bit_end  = (baud_q == BaudMax);
    // Pop happens on the same edge the FSM leaves IDLE or finishes STOP.
    pop      = !empty && ((state_q == StIdle) || ((state_q == StStop) && bit_end));
    // A full FIFO still accepts a push when a pop frees the head slot on that edge.
    push     = push_req && (!full || pop);
    ovf_set  = push_req && full && !pop;
    head     = mem_q[rd_ptr_q];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= WriteData[7:0];
        wr_ptr_q        <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
      if (ovf_set) begin
        overflow_q <= 1'b1;
      end else if (clr_req) begin
        overflow_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          tx_q <= 1'b1;
          if (pop) begin
            shift_q <= head;
            baud_q  <= '0;
            state_q <= StStart;
            tx_q    <= 1'b0;
          end
        end
        StStart: begin
          if (bit_end) begin
            baud_q    <= '0;
            bit_idx_q <= '0;
            state_q   <= StData;
            tx_q      <= shift_q[0];
          end else begin
            baud_q <= baud_q + BaudW'(1);
          end
        end
        StData: begin
          if (bit_end) begin
            baud_q    <= '0;
            shift_q   <= {1'b0, shift_q[7:1]};
            bit_idx_q <= bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) begin
              state_q <= StStop;
              tx_q    <= 1'b1;
            end else begin
              tx_q <= shift_q[1];
            end
          end else begin
            baud_q <= baud_q + BaudW'(1);
          end
        end
        StStop: begin
          if (bit_end) begin
            baud_q <= '0;
            if (pop) begin
              shift_q <= head;
              state_q <= StStart;
              tx_q    <= 1'b0;
            end else begin
              state_q <= StIdle;
              tx_q    <= 1'b1;
            end
          end else begin
            baud_q <= baud_q + BaudW'(1);
          end
        end
        default: begin
          state_q <= StIdle;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

  assign tx    = tx_q;
  assign busy  = (state_q != StIdle) || !empty;
  assign sel   = addr_tx || addr_st;
  assign rdata = addr_st ? {29'd0, overflow_q, full, busy} : 32'd0;

  logic unused_wdata;
  assign unused_wdata = ^{WriteData[31:8], WriteData[1:0]};

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: a serial monitor decodes frames and compares them against a
// queue of bytes expected from the stores issued, plus cycle-exact and status checks.
module tb_mmio_uart_tx;

  localparam int unsigned CPB  = 4;
  localparam logic [31:0] BASE = 32'h0000_0100;
  localparam logic [31:0] STAT = 32'h0000_0104;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWrite;
  logic [31:0] DataAdr;
  logic [31:0] WriteData;
  logic [31:0] rdata;
  logic        sel;
  logic        tx;
  logic        busy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int rst_cnt = 0;
  logic [7:0] exp_q[$];
  int starts[$];
  logic [7:0] pat;
  logic exp_bit;

  mmio_uart_tx #(
    .BASE_ADDR   (BASE),
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .MemWrite (MemWrite),
    .DataAdr  (DataAdr),
    .WriteData(WriteData),
    .rdata    (rdata),
    .sel      (sel),
    .tx       (tx),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc++;
    if (reset) rst_cnt++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Called just after a rising edge; the store is sampled at the next edge.
  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    MemWrite  = 1'b1;
    DataAdr   = addr;
    WriteData = data;
    @(posedge clk);
    #1;
    MemWrite  = 1'b0;
    DataAdr   = 32'd0;
    WriteData = 32'd0;
  endtask

  task automatic read_status(input string tag, input logic [31:0] exp);
    DataAdr = STAT;
    #1;
    check_eq(tag, rdata, exp);
    DataAdr = 32'd0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Serial monitor: start bit seen at a falling edge, each bit sampled one cycle into its window.
  initial begin : monitor
    logic [7:0] b;
    logic       stop_bit;
    int         rst_at_start;
    forever begin
      @(negedge clk);
      if (tx === 1'b0) begin
        starts.push_back(cyc);
        rst_at_start = rst_cnt;
        repeat (CPB + 1) @(negedge clk);
        b[0] = tx;
        for (int i = 1; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = tx;
        end
        repeat (CPB) @(negedge clk);
        stop_bit = tx;
        repeat (2) @(negedge clk);
        if (rst_cnt == rst_at_start) begin
          if (exp_q.size() == 0) begin
            check_eq("unexpected_frame", {24'd0, b}, 32'h0000_0100);
          end else begin
            check_eq("frame_data", {24'd0, b}, {24'd0, exp_q.pop_front()});
            check_eq("stop_bit", {31'd0, stop_bit}, 32'd1);
          end
        end
      end
    end
  end

  initial begin : stim
    reset     = 1'b1;
    MemWrite  = 1'b0;
    DataAdr   = 32'd0;
    WriteData = 32'd0;

    // Reset and address decode.
    idle(2);
    check_eq("reset_tx", {31'd0, tx}, 32'd1);
    check_eq("reset_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    read_status("status_reset", 32'h0);
    DataAdr = STAT;
    #1 check_eq("sel_status", {31'd0, sel}, 32'd1);
    DataAdr = BASE;
    #1 check_eq("sel_txdata", {31'd0, sel}, 32'd1);
    check_eq("rdata_txdata", rdata, 32'd0);
    DataAdr = 32'h0000_0108;
    #1 check_eq("sel_other", {31'd0, sel}, 32'd0);
    DataAdr = 32'd0;
    idle(3);

    // Single frame, cycle-exact: upper data bits must be ignored.
    pat = 8'hA5;
    exp_q.push_back(8'hA5);
    bus_write(BASE, 32'hFFFF_FFA5);
    check_eq("a5_pre_tx", {31'd0, tx}, 32'd1);
    for (int j = 1; j <= 41; j++) begin
      @(posedge clk);
      #1;
      if (j <= 4) exp_bit = 1'b0;
      else if (j <= 36) exp_bit = pat[(j - 5) / 4];
      else exp_bit = 1'b1;
      check_eq("a5_tx", {31'd0, tx}, {31'd0, exp_bit});
      check_eq("a5_busy", {31'd0, busy}, (j <= 40) ? 32'd1 : 32'd0);
    end
    idle(3);

    // Back-to-back frames.
    starts.delete();
    exp_q.push_back(8'h11);
    bus_write(BASE, 32'h11);
    exp_q.push_back(8'h22);
    bus_write(BASE, 32'h22);
    idle(90);
    check_eq("b2b_frames", starts.size(), 32'd2);
    if (starts.size() == 2) check_eq("b2b_gap", starts[1] - starts[0], 10 * CPB);
    check_eq("b2b_busy", {31'd0, busy}, 32'd0);

    // Fill past capacity: 0x01 pops on the second edge so 0x01..0x05 fit; later stores drop.
    for (int i = 1; i <= 5; i++) begin
      exp_q.push_back(8'(i));
      bus_write(BASE, i);
    end
    read_status("status_full", 32'h3);
    bus_write(BASE, 32'h06);
    read_status("status_ovf6", 32'h7);
    bus_write(BASE, 32'h07);
    read_status("status_ovf7", 32'h7);
    bus_write(STAT, 32'h4);
    read_status("status_clr", 32'h3);
    idle(215);
    check_eq("fill_busy", {31'd0, busy}, 32'd0);
    read_status("fill_status_end", 32'h0);

    // Push into a full FIFO on the exact edge of the end-of-STOP pop.
    exp_q.push_back(8'hB0);
    bus_write(BASE, 32'hB0);
    idle(9);
    for (int i = 1; i <= 4; i++) begin
      exp_q.push_back(8'hB0 + 8'(i));
      bus_write(BASE, 32'hB0 + i);
    end
    read_status("pp_status_full", 32'h3);
    idle(27);
    exp_q.push_back(8'hB5);
    bus_write(BASE, 32'hB5);
    read_status("pp_status_after", 32'h3);
    idle(5 * 10 * CPB + 10);
    check_eq("pp_busy", {31'd0, busy}, 32'd0);
    read_status("pp_status_end", 32'h0);

    // Reset during data bit 3 aborts the frame and discards the queued byte.
    starts.delete();
    bus_write(BASE, 32'hC3);
    bus_write(BASE, 32'h3C);
    idle(16);
    check_eq("abort_pre_tx", {31'd0, tx}, 32'd0);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    check_eq("abort_tx", {31'd0, tx}, 32'd1);
    check_eq("abort_busy", {31'd0, busy}, 32'd0);
    read_status("abort_status", 32'h0);
    idle(80);
    check_eq("abort_frames", starts.size(), 32'd1);
    check_eq("abort_idle_tx", {31'd0, tx}, 32'd1);
    check_eq("abort_idle_busy", {31'd0, busy}, 32'd0);

    check_eq("scoreboard_empty", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
